// File: rtl/synth_voice_bank.sv
// Time-multiplexed N-voice oscillator bank: one voice evaluated per clk, summed and scaled once per sample tick.
// Optional SYNTH_SINE_EN: wave 3 becomes a registered quarter-wave sine ROM, which adds one ACCUM cycle.
module synth_voice_bank #(
   parameter int NUM_VOICES = 8,
   parameter int PHASE_W    = 24,
   parameter int OUT_W      = 16,
   parameter int SAMPLE_DIV = 2268
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_VOICES)-1:0] cfg_addr,
   input  logic [PHASE_W-1:0]            cfg_inc,
   input  logic [1:0]                    cfg_wave,
   input  logic                          cfg_en,
   input  logic                          cfg_phase_rst,
   output logic signed [OUT_W-1:0]       out_sample,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overrun,
   input  logic                          overrun_clr,
   output logic                          busy
);
   localparam int VW    = $clog2(NUM_VOICES);
   localparam int ACC_W = OUT_W + VW;
   localparam int DIV_W = $clog2(SAMPLE_DIV);
`ifdef SYNTH_SINE_EN
   localparam logic [VW:0] LAST_V = (VW+1)'(NUM_VOICES);
`else
   localparam logic [VW:0] LAST_V = (VW+1)'(NUM_VOICES - 1);
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

   state_t                  state_q, state_d;
   logic [DIV_W-1:0]        cnt_q, cnt_d;
   logic [VW:0]             v_q, v_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [PHASE_W-1:0]      inc_q [NUM_VOICES];
   logic [PHASE_W-1:0]      inc_d [NUM_VOICES];
   logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]      phase_d [NUM_VOICES];
   logic [1:0]              wave_q [NUM_VOICES];
   logic [1:0]              wave_d [NUM_VOICES];
   logic [NUM_VOICES-1:0]   en_q, en_d;
   logic signed [OUT_W-1:0] out_sample_q, out_sample_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;
   logic                    busy_q, busy_d;

   logic                    tick, live, hs;
   logic [VW-1:0]           cur;
   logic [OUT_W-1:0]        u, samp, add;
   logic [OUT_W-2:0]        tri_t;
   logic signed [ACC_W-1:0] add_x, acc_sh;

   assign cur = v_q[VW-1:0];
   assign u   = phase_q[cur][PHASE_W-1 -: OUT_W];

`ifdef SYNTH_SINE_EN
   localparam int  IDX_W = (OUT_W >= 10) ? 8 : OUT_W - 2;
   localparam real AMP   = 2.0 ** (OUT_W - 1) - 1.0;

   function automatic logic [OUT_W-2:0] sine_entry(input int i);
      real x;
      x = AMP * $sin(1.5707963267948966 * real'(i) / real'(2 ** IDX_W));
      return (OUT_W-1)'($rtoi(x + 0.5));
   endfunction

   logic [OUT_W-2:0]  rom [2**IDX_W];
   logic [IDX_W-1:0]  rom_idx;
   logic [OUT_W-1:0]  mag, sine_s, pipe_q, pipe_d;

   for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rom
      assign rom[g] = sine_entry(g);
   end

   // second quadrant mirrors the table, lower half-cycle negates it
   always_comb begin
      rom_idx = u[OUT_W-2] ? ~u[OUT_W-3 -: IDX_W] : u[OUT_W-3 -: IDX_W];
      mag     = {1'b0, rom[rom_idx]};
      sine_s  = u[OUT_W-1] ? -mag : mag;
   end
`endif

   always_comb begin
      tri_t = u[OUT_W-1] ? ~u[OUT_W-2:0] : u[OUT_W-2:0];
      case (wave_q[cur])
         2'd0:    samp = u[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
         2'd1:    samp = {~u[OUT_W-1], u[OUT_W-2:0]};
`ifdef SYNTH_SINE_EN
         2'd3:    samp = sine_s;
`endif
         default: samp = {~tri_t[OUT_W-2], tri_t[OUT_W-3:0], 1'b0};
      endcase
   end

   always_comb begin
      tick  = (cnt_q == DIV_W'(SAMPLE_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      hs    = out_valid_q & out_ready;
      live  = (state_q == ACCUM) && (v_q < (VW+1)'(NUM_VOICES));

      state_d      = state_q;
      v_d          = v_q;
      acc_d        = acc_q;
      busy_d       = busy_q;
      inc_d        = inc_q;
      wave_d       = wave_q;
      en_d         = en_q;
      phase_d      = phase_q;
      out_sample_d = out_sample_q;
      out_valid_d  = out_valid_q & ~hs;
      overrun_d    = overrun_q & ~overrun_clr;
      acc_sh       = acc_q >>> VW;

`ifdef SYNTH_SINE_EN
      pipe_d = pipe_q;
      if (live) pipe_d = en_q[cur] ? samp : '0;
      add = (v_q != '0) ? pipe_q : '0;
`else
      add = (live && en_q[cur]) ? samp : '0;
`endif
      add_x = {{VW{add[OUT_W-1]}}, add};

      if (live && en_q[cur]) phase_d[cur] = phase_q[cur] + inc_q[cur];

      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = ACCUM;
               busy_d  = 1'b1;
               acc_d   = '0;
               v_d     = '0;
            end
         end
         ACCUM: begin
            acc_d = acc_q + add_x;
            v_d   = v_q + 1'b1;
            if (v_q == LAST_V) state_d = FINISH;
         end
         FINISH: begin
            out_sample_d = acc_sh[OUT_W-1:0];
            out_valid_d  = 1'b1;
            if (out_valid_q && !out_ready) overrun_d = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // a host write overrides the same-cycle phase advance of that voice
      if (cfg_we) begin
         inc_d[cfg_addr]  = cfg_inc;
         wave_d[cfg_addr] = cfg_wave;
         en_d[cfg_addr]   = cfg_en;
         if (cfg_phase_rst) phase_d[cfg_addr] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         v_q          <= '0;
         acc_q        <= '0;
         en_q         <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            inc_q[i]   <= '0;
            phase_q[i] <= '0;
            wave_q[i]  <= '0;
         end
`ifdef SYNTH_SINE_EN
         pipe_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         v_q          <= v_d;
         acc_q        <= acc_d;
         en_q         <= en_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
         inc_q        <= inc_d;
         phase_q      <= phase_d;
         wave_q       <= wave_d;
`ifdef SYNTH_SINE_EN
         pipe_q <= pipe_d;
`endif
      end
   end

   assign out_sample = out_sample_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_synth_voice_bank.sv
// Bench for synth_voice_bank: arithmetic voice model feeds an expected-sample queue; a negedge monitor checks output.
// Build with SYNTH_SINE_EN to check the sine variant (latency and wave 3 model follow the macro).
module tb_synth_voice_bank;
   localparam int PW = 24, OW = 16, N = 8, LOGN = 3, SDIV = 24;
`ifdef SYNTH_SINE_EN
   localparam int BUSY_LEN = N + 2;
   localparam int TOL      = 2;
`else
   localparam int BUSY_LEN = N + 1;
   localparam int TOL      = 0;
`endif
   localparam longint MASK = (longint'(1) << PW) - 1;
   localparam int HALF = 1 << (OW - 1);

   logic clk = 0, rst_n = 0;
   logic cfg_we = 0, cfg_en = 0, cfg_phase_rst = 0;
   logic [2:0] cfg_addr = '0;
   logic [PW-1:0] cfg_inc = '0;
   logic [1:0] cfg_wave = '0;
   logic signed [OW-1:0] out_sample;
   logic out_valid, overrun, busy;
   logic out_ready = 1, overrun_clr = 0;

   synth_voice_bank #(.NUM_VOICES(N), .PHASE_W(PW), .OUT_W(OW), .SAMPLE_DIV(SDIV)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_inc(cfg_inc),
      .cfg_wave(cfg_wave), .cfg_en(cfg_en), .cfg_phase_rst(cfg_phase_rst),
      .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   longint inc_m [N], phase_m [N];
   int wave_m [N];
   bit en_m [N];
   int pend [$];
   bit mon_en = 0, rnd_ready = 0;

   task automatic chk(input string nm, input int act, input int exp, input int tol = 0);
      n_cmp++;
      if ((act > exp ? act - exp : exp - act) > tol) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int wave_val(input longint ph, input int w);
      int u, t, q, f, k, m;
      u = int'(ph >> (PW - OW));
      case (w)
         0: return (u < HALF) ? HALF - 1 : -HALF;
         1: return u - HALF;
`ifdef SYNTH_SINE_EN
         3: begin
            q = u >> (OW - 2);
            f = (u >> (OW - 2 - 8)) % 256;
            k = (q % 2 == 1) ? 255 - f : f;
            m = $rtoi((HALF - 1.0) * $sin(1.5707963267948966 * k / 256.0) + 0.5);
            return (q >= 2) ? -m : m;
         end
`endif
         default: begin
            t = (u < HALF) ? u : 2 * HALF - 1 - u;
            return 2 * t - HALF;
         end
      endcase
   endfunction

   // a pass starts: evaluate every voice at its current phase, then advance
   always @(posedge busy) begin
      if (mon_en) begin
         int sum;
         sum = 0;
         for (int i = 0; i < N; i++) begin
            if (en_m[i]) begin
               sum += wave_val(phase_m[i], wave_m[i]);
               phase_m[i] = (phase_m[i] + inc_m[i]) & MASK;
            end
         end
         pend.push_back(sum >>> LOGN);
      end
   end

   int cyc = 0, last_rise = -1, n_falls = 0, n_rises = 0, shown = 0;
   bit busy_p = 0, have_shown = 0, exp_ovr = 0, clr_p = 0, set_now = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n || !mon_en) begin
         have_shown = 0; exp_ovr = 0; clr_p = 0; last_rise = -1;
         pend.delete();
      end else begin
         set_now = 0;
         if (busy && !busy_p) begin
            if (last_rise >= 0) chk("tick_period", cyc - last_rise, SDIV);
            last_rise = cyc;
            n_rises++;
         end
         if (!busy && busy_p) begin
            chk("busy_len", cyc - last_rise, BUSY_LEN);
            n_falls++;
            if (pend.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sample_queue: got output with 0 expected entries, required 1");
            end else begin
               if (have_shown) set_now = 1;
               shown = pend.pop_front();
               have_shown = 1;
            end
         end
         exp_ovr = set_now ? 1'b1 : (clr_p ? 1'b0 : exp_ovr);
         clr_p = overrun_clr;
         chk("out_valid", out_valid, have_shown);
         chk("overrun", overrun, exp_ovr);
         if (out_valid && out_ready && have_shown) begin
            chk("out_sample", int'(out_sample), shown, TOL);
            have_shown = 0;
         end
      end
      busy_p = busy;
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1 out_ready = ($urandom_range(0, 99) < 60);
      end
   end

   task automatic wait_fall();
      int start;
      start = n_falls;
      for (int i = 0; i < 4 * SDIV; i++) begin
         @(negedge clk); #1;
         if (n_falls != start) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL wait_fall: no pass end within %0d cycles, required 1", 4 * SDIV);
   endtask

   task automatic wait_rise();
      int start;
      start = n_rises;
      for (int i = 0; i < 4 * SDIV; i++) begin
         @(negedge clk); #1;
         if (n_rises != start) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL wait_rise: no pass start within %0d cycles, required 1", 4 * SDIV);
   endtask

   task automatic cfg_write(input int a, input logic [PW-1:0] inc, input int w, input bit en, input bit prst);
      @(posedge clk); #1;
      cfg_we = 1; cfg_addr = 3'(a); cfg_inc = inc; cfg_wave = 2'(w); cfg_en = en; cfg_phase_rst = prst;
      inc_m[a] = longint'(inc); wave_m[a] = w; en_m[a] = en;
      if (prst) phase_m[a] = 0;
   endtask

   task automatic cfg_end();
      @(posedge clk); #1;
      cfg_we = 0; cfg_phase_rst = 0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 overrun_clr = 1;
      @(posedge clk); #1 overrun_clr = 0;
   endtask

   int nw;

   initial begin
      for (int i = 0; i < N; i++) begin
         inc_m[i] = 0; phase_m[i] = 0; wave_m[i] = 0; en_m[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_sample", int'(out_sample), 0);
      @(posedge clk); #1 rst_n = 1; mon_en = 1;

      repeat (3) wait_fall();                                   // idle bank mixes to 0

      cfg_write(0, PW'(1 << (PW - 1)), 0, 1, 1); cfg_end();     // alternating square
      repeat (4) wait_fall();

      cfg_write(0, PW'(1 << (PW - 4)), 1, 1, 1); cfg_end();     // saw ramp with wrap
      repeat (18) wait_fall();
      cfg_write(0, PW'(1 << (PW - 4)), 1, 1, 1); cfg_end();
      repeat (3) wait_fall();

      @(posedge clk); #1 out_ready = 0;                         // two unconsumed samples
      wait_fall();
      wait_fall();
      chk("overrun_after_two", overrun, 1);
      pulse_clr();
      @(negedge clk);
      chk("overrun_cleared", overrun, 0);
      @(posedge clk); #1 out_ready = 1;
      wait_fall();

      @(posedge clk); #1 out_ready = 0;                         // all voices square at phase 0
      for (int i = 0; i < N; i++) cfg_write(i, '0, 0, 1, 1);
      cfg_end();
      wait_fall();
      wait_rise();
      repeat (BUSY_LEN - 1) @(posedge clk);
      #1 out_ready = 1;                                         // handshake lands on the FINISH edge
      wait_fall();
      chk("finish_hs_no_overrun", overrun, 0);
      chk("finish_hs_valid", out_valid, 1);
      chk("all_square_max", int'(out_sample), HALF - 1);

      cfg_write(0, PW'(1 << (PW - 2)), 3, 1, 1);                // quarter-rate wave 3, others off
      for (int i = 1; i < N; i++) cfg_write(i, '0, 0, 0, 1);
      cfg_end();
      repeat (5) wait_fall();

      rnd_ready = 1;
      for (int p = 0; p < 40; p++) begin
         wait_fall();
         nw = $urandom_range(0, 3);
         for (int k = 0; k < nw; k++)
            cfg_write($urandom_range(0, N - 1), PW'($urandom), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
         cfg_end();
         if ($urandom_range(0, 3) == 0) pulse_clr();
      end
      wait_fall();
      rnd_ready = 0;
      @(posedge clk); #1 out_ready = 1;
      repeat (3) wait_fall();

      wait_rise();                                              // reset in the middle of a pass
      @(posedge clk); #1 mon_en = 0; rst_n = 0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_out_sample", int'(out_sample), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      repeat (60000) @(posedge clk);
      n_cmp++; n_bad++;
      $display("FAIL watchdog: run exceeded %0d cycles, required completion", 60000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
